// File: rtl/bus_loader_pkg.sv
// Shared state encodings, reset constants and grant-timeout helpers for bus_loader.
package bus_loader_pkg;

    typedef logic [2:0] state_t;

    localparam state_t S_IDLE      = 3'd0;
    localparam state_t S_REQ       = 3'd1;
    localparam state_t S_OWN       = 3'd2;
    localparam state_t S_WAIT_BYTE = 3'd3;
    localparam state_t S_WRITE     = 3'd4;
    localparam state_t S_VERIFY    = 3'd5;
    localparam state_t S_DONE      = 3'd6;
    localparam state_t S_ERR       = 3'd7;

    localparam int GNT_TIMEOUT_DEF = 255;

    localparam state_t       RST_STATE = S_IDLE;
    localparam logic         RST_FLAG  = 1'b0;
    localparam logic [15:0]  RST_CNT   = 16'd0;
    localparam logic [63:0]  RST_BUS   = 64'd0;

    function automatic int tmr_width(input int timeout);
        return (timeout < 2) ? 1 : $clog2(timeout + 1);
    endfunction

    // The timer expires on its last REQ cycle, so it is loaded one short.
    function automatic int tmr_load_val(input int timeout);
        return (timeout > 0) ? timeout - 1 : 0;
    endfunction

endpackage

// File: rtl/bus_loader_timer.sv
// Loadable down-counter for the bus-grant timeout; expired is the terminal-count compare.
module bus_loader_timer
    import bus_loader_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    output logic         expired
);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= W'(RST_CNT);
        end else if (load) begin
            cnt_q <= load_val;
        end else if (en && (cnt_q != '0)) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign expired = (cnt_q == '0);

endmodule

// File: rtl/bus_loader.sv
// Host-to-RAM bus loader: takes the CPU buses and writes a byte stream to consecutive
// addresses. Defining LOADER_VERIFY_EN adds a read-back compare after every write.
//
// state     | meaning
// IDLE      | waiting for start
// REQ       | bus_req high, grant timer running
// OWN       | grant seen, address driven
// WAIT_BYTE | byte_ready high, waiting for the host byte
// WRITE     | mem_we pulse, address and data stable
// VERIFY    | mem_oe pulse, data_in compared (LOADER_VERIFY_EN only)
// DONE      | buses released, done pulse (err instead after abort)
// ERR       | buses released, err pulse
module bus_loader
    import bus_loader_pkg::*;
#(
    parameter int ADDR_W      = 16,
    parameter int DATA_W      = 8,
    parameter int GNT_TIMEOUT = GNT_TIMEOUT_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [15:0]       len,
    input  logic              abort,
    input  logic              byte_valid,
    input  logic [DATA_W-1:0] byte_data,
    output logic              byte_ready,
    output logic              bus_req,
    input  logic              bus_gnt,
    output logic              drive_en,
    output logic [ADDR_W-1:0] addr_out,
    output logic [DATA_W-1:0] data_out,
    output logic              mem_we,
    output logic              mem_oe,
    input  logic [DATA_W-1:0] data_in,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              mismatch
);

    localparam int               TMR_W    = tmr_width(GNT_TIMEOUT);
    localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(tmr_load_val(GNT_TIMEOUT));

    state_t              state_q;
    state_t              state_d;
    state_t              adv_state;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   data_q;
    logic [15:0]         rem_q;
    logic                aborted_q;
    logic                owned;
    logic                accept_start;
    logic                tmr_load;
    logic                tmr_expired;
    logic                handshake;
    logic                advance;

    assign owned        = state_q inside {S_OWN, S_WAIT_BYTE, S_WRITE, S_VERIFY};
    assign accept_start = (state_q == S_IDLE) && start;
    assign tmr_load     = accept_start && (len != 16'd0);
    assign handshake    = (state_q == S_WAIT_BYTE) && byte_valid;
    assign adv_state    = (aborted_q || abort || (rem_q == 16'd1)) ? S_DONE : S_WAIT_BYTE;

`ifdef LOADER_VERIFY_EN
    assign advance = (state_q == S_VERIFY) && bus_gnt;
`else
    assign advance = (state_q == S_WRITE) && bus_gnt;
`endif

    bus_loader_timer #(
        .W (TMR_W)
    ) u_gnt_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (tmr_load),
        .load_val (TMR_LOAD),
        .en       (state_q == S_REQ),
        .expired  (tmr_expired)
    );

    // Losing the grant outranks everything else while the buses are owned.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = (len != 16'd0) ? S_REQ : S_DONE;
                end
            end
            S_REQ: begin
                if (abort)            state_d = S_ERR;
                else if (bus_gnt)     state_d = S_OWN;
                else if (tmr_expired) state_d = S_ERR;
            end
            S_OWN: begin
                if (!bus_gnt)         state_d = S_ERR;
                else if (abort)       state_d = S_DONE;
                else                  state_d = S_WAIT_BYTE;
            end
            S_WAIT_BYTE: begin
                if (!bus_gnt)         state_d = S_ERR;
                else if (abort)       state_d = S_DONE;
                else if (byte_valid)  state_d = S_WRITE;
            end
            S_WRITE: begin
`ifdef LOADER_VERIFY_EN
                state_d = bus_gnt ? S_VERIFY : S_ERR;
`else
                state_d = bus_gnt ? adv_state : S_ERR;
`endif
            end
`ifdef LOADER_VERIFY_EN
            S_VERIFY: begin
                state_d = bus_gnt ? adv_state : S_ERR;
            end
`endif
            S_DONE:  state_d = S_IDLE;
            S_ERR:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= RST_STATE;
            addr_q    <= RST_BUS[ADDR_W-1:0];
            data_q    <= RST_BUS[DATA_W-1:0];
            rem_q     <= RST_CNT;
            aborted_q <= RST_FLAG;
        end else begin
            state_q <= state_d;
            if (state_q == S_IDLE) begin
                aborted_q <= RST_FLAG;
            end else if (owned && abort) begin
                aborted_q <= 1'b1;
            end
            if (tmr_load) begin
                addr_q <= base_addr;
                rem_q  <= len;
            end else if (advance) begin
                addr_q <= addr_q + 1'b1;
                rem_q  <= rem_q - 16'd1;
            end
            if (handshake) begin
                data_q <= byte_data;
            end
        end
    end

`ifdef LOADER_VERIFY_EN
    logic mismatch_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mismatch_q <= RST_FLAG;
        end else if (accept_start) begin
            mismatch_q <= RST_FLAG;
        end else if ((state_q == S_VERIFY) && (data_in != data_q)) begin
            mismatch_q <= 1'b1;
        end
    end

    assign mem_oe   = (state_q == S_VERIFY);
    assign mismatch = mismatch_q;
`else
    logic unused_data_in;
    assign unused_data_in = ^data_in;
    assign mem_oe         = 1'b0;
    assign mismatch       = 1'b0;
`endif

    assign bus_req    = (state_q == S_REQ) || owned;
    assign drive_en   = owned;
    assign mem_we     = (state_q == S_WRITE);
    assign byte_ready = (state_q == S_WAIT_BYTE);
    assign busy       = (state_q != S_IDLE);
    assign done       = (state_q == S_DONE) && !aborted_q;
    assign err        = (state_q == S_ERR) || ((state_q == S_DONE) && aborted_q);
    assign addr_out   = addr_q;
    assign data_out   = data_q;

endmodule

// File: tb/tb_bus_loader.sv
// Directed and randomised bench for bus_loader with a RAM-like write log and readback echo.
module tb_bus_loader;

    localparam int TO = 8;
`ifdef LOADER_VERIFY_EN
    localparam bit VERIFY = 1'b1;
`else
    localparam bit VERIFY = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [15:0] base_addr = 16'd0;
    logic [15:0] len = 16'd0;
    logic        abort = 1'b0;
    logic        byte_valid = 1'b0;
    logic [7:0]  byte_data = 8'd0;
    logic        bus_gnt = 1'b0;
    logic        corrupt = 1'b0;
    logic        byte_ready, bus_req, drive_en, mem_we, mem_oe, busy, done, err, mismatch;
    logic [15:0] addr_out;
    logic [7:0]  data_out;
    logic [7:0]  data_in;

    // RAM readback: echoes the driven byte unless the bench corrupts it.
    assign data_in = corrupt ? 8'h00 : data_out;

    bus_loader #(
        .ADDR_W      (16),
        .DATA_W      (8),
        .GNT_TIMEOUT (TO)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .base_addr  (base_addr),
        .len        (len),
        .abort      (abort),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .byte_ready (byte_ready),
        .bus_req    (bus_req),
        .bus_gnt    (bus_gnt),
        .drive_en   (drive_en),
        .addr_out   (addr_out),
        .data_out   (data_out),
        .mem_we     (mem_we),
        .mem_oe     (mem_oe),
        .data_in    (data_in),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .mismatch   (mismatch)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;
    int done_cnt = 0, err_cnt = 0, req_cnt = 0, oe_cnt = 0, de_viol = 0;
    logic gnt_prev = 1'b0;
    logic [23:0] wr_q [$];
    logic [7:0]  src [$];

    always @(posedge clk) gnt_prev <= bus_gnt;

    always @(negedge clk) begin
        if (rst_n) begin
            if (mem_we) wr_q.push_back({addr_out, data_out});
            if (done) done_cnt++;
            if (err) err_cnt++;
            if (bus_req) req_cnt++;
            if (mem_oe) oe_cnt++;
            if (drive_en && !gnt_prev) de_viol++;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(input string tag);
        int k;
        k = 0;
        while (!byte_ready && k < 50) begin
            tick();
            k++;
        end
        check(tag, 32'(byte_ready), 32'd1);
    endtask

    // Full transfer from src; drop_after in 1..n removes the grant during that write.
    task automatic xfer(input logic [15:0] base, input int n, input int gnt_dly, input int drop_after);
        int  d0, e0, r0, o0, idx, wr_seen, exp_wr, verified;
        bit  drop_on;
        logic hs;
        logic exp_mm;
        drop_on  = (drop_after > 0) && (drop_after <= n);
        exp_wr   = drop_on ? drop_after : n;
        verified = drop_on ? exp_wr - 1 : exp_wr;
        wr_q.delete();
        d0 = done_cnt; e0 = err_cnt; r0 = req_cnt; o0 = oe_cnt;
        bus_gnt = 1'b0;
        base_addr = base;
        len = 16'(n);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("xfer_mm_clear", 32'(mismatch), 32'd0);
        for (int i = 0; i < gnt_dly; i++) tick();
        bus_gnt = 1'b1;
        idx = 0;
        wr_seen = 0;
        for (int cyc = 0; cyc < 500 && busy; cyc++) begin
            hs = byte_valid && byte_ready;
            tick();
            if (hs) begin
                idx++;
                byte_valid = 1'b0;
            end
            if (mem_we) wr_seen++;
            if (drop_on && mem_we && wr_seen == drop_after) begin
                bus_gnt = 1'b0;
                tick();
                check("gnt_drop_flags", 32'({err, drive_en, mem_we}), 32'b100);
            end
            if (idx < n && !byte_valid && $urandom_range(0, 3) != 0) begin
                byte_valid = 1'b1;
                byte_data  = src[idx];
            end
        end
        byte_valid = 1'b0;
        bus_gnt = 1'b0;
        check("xfer_idle", 32'({busy, bus_req, drive_en}), 32'd0);
        check("xfer_wr_count", 32'(wr_q.size()), 32'(exp_wr));
        for (int i = 0; i < exp_wr && i < wr_q.size(); i++)
            check("xfer_wr", 32'(wr_q[i]), {8'h00, 16'(base + 16'(i)), src[i]});
        check("xfer_done", 32'(done_cnt - d0), drop_on ? 32'd0 : 32'd1);
        check("xfer_err", 32'(err_cnt - e0), drop_on ? 32'd1 : 32'd0);
        check("xfer_oe", 32'(oe_cnt - o0), VERIFY ? 32'(verified) : 32'd0);
        if (n == 0) check("xfer_len0_noreq", 32'(req_cnt - r0), 32'd0);
        exp_mm = 1'b0;
        for (int i = 0; i < verified; i++)
            if (VERIFY && corrupt && src[i] != 8'h00) exp_mm = 1'b1;
        check("xfer_mismatch", 32'(mismatch), 32'(exp_mm));
    endtask

    initial begin
        int d0, e0, n;
        logic [15:0] b;

        // Reset state
        tick();
        check("rst_flags", 32'({busy, bus_req, drive_en, byte_ready, mem_we, mem_oe, done, err, mismatch}), 32'd0);
        check("rst_bus", 32'({addr_out, data_out}), 32'd0);
        rst_n = 1'b1;
        tick();
        check("rst_release_idle", 32'(busy), 32'd0);

        // Basic stream, grant after 2 cycles
        src = '{8'h11, 8'h22, 8'h33};
        xfer(16'h8000, 3, 2, 0);

        // Address wrap
        src = '{8'hC3, 8'h3C};
        xfer(16'hFFFF, 2, 1, 0);

        // Zero length: done pulse without ever requesting the bus
        xfer(16'h4000, 0, 0, 0);

        // Grant timeout
        e0 = err_cnt;
        bus_gnt = 1'b0;
        base_addr = 16'h3000;
        len = 16'd1;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("to_req_entry", 32'(bus_req), 32'd1);
        for (int i = 1; i < TO; i++) tick();
        check("to_before", 32'({err, bus_req}), 32'b01);
        tick();
        check("to_err", 32'({err, bus_req, drive_en}), 32'b100);
        tick();
        check("to_idle", 32'(busy), 32'd0);
        check("to_err_cnt", 32'(err_cnt - e0), 32'd1);

        // Grant lost after the second of four writes
        src.delete();
        for (int i = 0; i < 4; i++) src.push_back(8'($urandom));
        xfer(16'($urandom), 4, 1, 2);

        // Corrupted readback; mismatch must survive until the next start
        corrupt = 1'b1;
        src = '{8'h5A};
        xfer(16'h2000, 1, 0, 0);
        corrupt = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        check("mm_persist", 32'(mismatch), 32'(VERIFY));
        src = '{8'h77};
        xfer(16'h2001, 1, 0, 0);

        // Abort while waiting for a byte, with a stray start ignored in REQ
        d0 = done_cnt;
        e0 = err_cnt;
        wr_q.delete();
        base_addr = 16'h1234;
        len = 16'd3;
        bus_gnt = 1'b1;
        start = 1'b1;
        tick();
        base_addr = 16'h0000;
        len = 16'd0;
        tick();
        start = 1'b0;
        wait_ready("ab_ready1");
        byte_valid = 1'b1;
        byte_data = 8'hA1;
        tick();
        byte_valid = 1'b0;
        check("ab_we", 32'(mem_we), 32'd1);
        check("ab_wr", 32'({addr_out, data_out}), 32'h1234A1);
        tick();
        wait_ready("ab_ready2");
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("ab_flags", 32'({done, err, drive_en, bus_req}), 32'b0100);
        tick();
        check("ab_idle", 32'(busy), 32'd0);
        check("ab_done_cnt", 32'(done_cnt - d0), 32'd0);
        check("ab_err_cnt", 32'(err_cnt - e0), 32'd1);
        check("ab_wr_count", 32'(wr_q.size()), 32'd1);
        bus_gnt = 1'b0;

        // Abort while requesting
        base_addr = 16'h5000;
        len = 16'd2;
        start = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abreq_flags", 32'({err, bus_req, done}), 32'b100);
        tick();
        check("abreq_idle", 32'(busy), 32'd0);

        // Reset in WAIT_BYTE releases everything at once
        base_addr = 16'h0100;
        len = 16'd2;
        start = 1'b1;
        tick();
        start = 1'b0;
        bus_gnt = 1'b1;
        wait_ready("rstw_ready");
        d0 = done_cnt;
        e0 = err_cnt;
        #2 rst_n = 1'b0;
        #1;
        check("rstw_flags", 32'({busy, bus_req, drive_en, byte_ready, mem_we, mem_oe, done, err, mismatch}), 32'd0);
        check("rstw_bus", 32'({addr_out, data_out}), 32'd0);
        tick();
        rst_n = 1'b1;
        bus_gnt = 1'b0;
        tick();
        check("rstw_pulses", 32'((done_cnt - d0) + (err_cnt - e0)), 32'd0);
        src = '{8'h9E, 8'hE9};
        xfer(16'h0100, 2, 3, 0);

        // Randomised transfers
        for (int t = 0; t < 4; t++) begin
            n = int'($urandom_range(1, 6));
            b = 16'($urandom);
            src.delete();
            for (int i = 0; i < n; i++) src.push_back(8'($urandom));
            xfer(b, n, int'($urandom_range(0, 5)), 0);
        end

        check("drive_needs_gnt", 32'(de_viol), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
